// File: rtl/kaiser_pkg.sv
// Shared types and constants for the writeback pipeline slice: the per-stage
// record carried through the in-flight pipeline and the default geometry.
package kaiser_pkg;

  localparam int DATA_W             = 16;
  localparam int REG_W              = 3;
  localparam int DEFAULT_DEPTH      = 6;
  localparam int DEFAULT_LOAD_STAGE = 3;

  typedef struct packed {
    logic [REG_W-1:0]  num;
    logic [DATA_W-1:0] data;
    logic              write;
    logic              pending;
  } stage_t;

endpackage

// File: rtl/writeback_pipe_if.sv
// Issue/load/flush inputs, per-stage forwarding outputs and register-file read
// port of writeback_pipe; master drives the pipe, slave is the pipe itself.
interface writeback_pipe_if #(
  parameter int DEPTH = kaiser_pkg::DEFAULT_DEPTH
);
  import kaiser_pkg::*;

  logic                    issue_valid_in;
  logic [REG_W-1:0]        issue_num_in;
  logic                    issue_write_in;
  logic                    issue_load_in;
  logic [DATA_W-1:0]       issue_data_in;
  logic                    mem_valid_in;
  logic [DATA_W-1:0]       mem_data_in;
  logic                    stall_in;
  logic [DEPTH-1:0]        flush_mask_in;
  logic [DEPTH*REG_W-1:0]  num_m_out;
  logic [DEPTH*DATA_W-1:0] data_m_out;
  logic [DEPTH-1:0]        write_m_out;
  logic [DEPTH-1:0]        pending_m_out;
  logic                    busy_out;
  logic [REG_W-1:0]        rd_num_in;
  logic [DATA_W-1:0]       rd_data_out;

  modport master (
    output issue_valid_in, issue_num_in, issue_write_in, issue_load_in, issue_data_in,
    output mem_valid_in, mem_data_in, stall_in, flush_mask_in, rd_num_in,
    input  num_m_out, data_m_out, write_m_out, pending_m_out, busy_out, rd_data_out
  );

  modport slave (
    input  issue_valid_in, issue_num_in, issue_write_in, issue_load_in, issue_data_in,
    input  mem_valid_in, mem_data_in, stall_in, flush_mask_in, rd_num_in,
    output num_m_out, data_m_out, write_m_out, pending_m_out, busy_out, rd_data_out
  );

endinterface

// File: rtl/regfile_8x16.sv
// 8x16 register file: async read, sync write, async reset to zero.
// Define WB_BYPASS_EN to let a same-cycle write show through on the read port.
module regfile_8x16
  import kaiser_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              we,
  input  logic [REG_W-1:0]  wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  rd_num,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [0:(1<<REG_W)-1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < (1<<REG_W); i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_num] <= wr_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through: the retiring value is visible in the same cycle.
  assign rd_data = (we && (wr_num == rd_num)) ? wr_data : regs[rd_num];
`else
  assign rd_data = regs[rd_num];
`endif

endmodule

// File: rtl/writeback_pipe.sv
// Age-ordered in-flight result pipeline feeding the forwarding muxes; retires the
// oldest stage into regfile_8x16 (WB_BYPASS_EN selects read write-through there).
module writeback_pipe
  import kaiser_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int LOAD_STAGE = DEFAULT_LOAD_STAGE
) (
  input logic             clk_in,
  input logic             rst_in,
  writeback_pipe_if.slave bus
);

  stage_t stages      [1:DEPTH];
  stage_t next_stages [1:DEPTH];
  stage_t issue_entry;
  stage_t filled_entry;
  logic   busy;
  logic   fill;
  logic   advance;
  logic   retire_we;

  // A load still waiting at LOAD_STAGE freezes everything until its data shows up.
  assign busy      = stages[LOAD_STAGE].pending && !bus.mem_valid_in;
  assign fill      = stages[LOAD_STAGE].pending &&  bus.mem_valid_in;
  assign advance   = !bus.stall_in && !busy;
  assign retire_we = advance && stages[DEPTH].write;

  always_comb begin
    issue_entry.num     = bus.issue_num_in;
    issue_entry.data    = bus.issue_data_in;
    issue_entry.write   = bus.issue_valid_in && bus.issue_write_in;
    issue_entry.pending = bus.issue_valid_in && bus.issue_load_in;
  end

  always_comb begin
    filled_entry = stages[LOAD_STAGE];
    if (fill) begin
      filled_entry.data    = bus.mem_data_in;
      filled_entry.pending = 1'b0;
    end
  end

  // Shift or hold first, then apply the flush mask to the post-edge positions.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) next_stages[k] = stages[k];
    next_stages[LOAD_STAGE] = filled_entry;
    if (advance) begin
      next_stages[1] = issue_entry;
      for (int k = 2; k <= DEPTH; k++) begin
        next_stages[k] = ((k - 1) == LOAD_STAGE) ? filled_entry : stages[k-1];
      end
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (bus.flush_mask_in[k-1]) begin
        next_stages[k].write   = 1'b0;
        next_stages[k].pending = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 1; k <= DEPTH; k++) stages[k] <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) stages[k] <= next_stages[k];
    end
  end

  for (genvar g = 1; g <= DEPTH; g++) begin : g_out
    assign bus.num_m_out[g*REG_W-1 -: REG_W]   = stages[g].num;
    assign bus.data_m_out[g*DATA_W-1 -: DATA_W] = stages[g].data;
    assign bus.write_m_out[g-1]                = stages[g].write;
    assign bus.pending_m_out[g-1]              = stages[g].pending;
  end

  assign bus.busy_out = busy;

  regfile_8x16 u_regfile (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .we      (retire_we),
    .wr_num  (stages[DEPTH].num),
    .wr_data (stages[DEPTH].data),
    .rd_num  (bus.rd_num_in),
    .rd_data (bus.rd_data_out)
  );

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe: a vector table for ALU traffic and flushes,
// plus hand sequences for stalls, loads, fills under stall and async reset.
module tb_writeback_pipe;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        iv;
    logic [2:0]  inum;
    logic [15:0] idata;
    logic [5:0]  flush;
    logic [2:0]  rdn;
    logic [5:0]  exp_write;
    logic [5:0]  exp_pend;
    logic        exp_busy;
    logic [15:0] exp_rd;
    int          chk_k;
    logic [15:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  vec_t vecs[$];

  writeback_pipe_if #(.DEPTH(6)) bus();

  writeback_pipe #(.DEPTH(6), .LOAD_STAGE(3)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t alu(logic iv, logic [2:0] num, logic [15:0] d, logic [5:0] fl,
                               logic [2:0] rdn, logic [5:0] ew, logic [15:0] er,
                               int ck, logic [15:0] ed);
    vec_t v;
    v.iv = iv; v.inum = num; v.idata = d; v.flush = fl; v.rdn = rdn;
    v.exp_write = ew; v.exp_pend = 6'b0; v.exp_busy = 1'b0; v.exp_rd = er;
    v.chk_k = ck; v.exp_data = ed;
    return v;
  endfunction

  function automatic logic [15:0] stage_data(int k);
    logic [95:0] all;
    all = bus.data_m_out;
    return all[k*16-1 -: 16];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [2:0] num, input logic w, input logic l,
                       input logic [15:0] d, input logic mv, input logic [15:0] md,
                       input logic st, input logic [5:0] fl);
    bus.issue_valid_in = iv;
    bus.issue_num_in   = num;
    bus.issue_write_in = w;
    bus.issue_load_in  = l;
    bus.issue_data_in  = d;
    bus.mem_valid_in   = mv;
    bus.mem_data_in    = md;
    bus.stall_in       = st;
    bus.flush_mask_in  = fl;
  endtask

  task automatic bubble();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 6'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bubble();
    #1;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    drive(v.iv, v.inum, v.iv, 1'b0, v.idata, 1'b0, 16'h0, 1'b0, v.flush);
    bus.rd_num_in = v.rdn;
    tick();
    checkOutput($sformatf("v%0d.write", idx), 32'(bus.write_m_out), 32'(v.exp_write));
    checkOutput($sformatf("v%0d.pend", idx), 32'(bus.pending_m_out), 32'(v.exp_pend));
    checkOutput($sformatf("v%0d.busy", idx), 32'(bus.busy_out), 32'(v.exp_busy));
    checkOutput($sformatf("v%0d.rd", idx), 32'(bus.rd_data_out), 32'(v.exp_rd));
    if (v.chk_k != 0)
      checkOutput($sformatf("v%0d.data%0d", idx, v.chk_k), 32'(stage_data(v.chk_k)), 32'(v.exp_data));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    bus.rd_num_in = 3'd0;
    bubble();
    #12;
    rst = 1'b0;
    #1;
    checkOutput("reset.write", 32'(bus.write_m_out), 32'h0);
    checkOutput("reset.pend", 32'(bus.pending_m_out), 32'h0);
    checkOutput("reset.num", 32'(bus.num_m_out), 32'h0);
    checkOutput("reset.data_lo", bus.data_m_out[31:0], 32'h0);
    checkOutput("reset.busy", 32'(bus.busy_out), 32'h0);
    checkOutput("reset.rd", 32'(bus.rd_data_out), 32'h0);

    // Single write flowing through all stages and retiring.
    vecs.push_back(alu(1, 2, 16'h1234, 6'b0, 2, 6'b000001, 16'h0, 1, 16'h1234));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 2, 6'b000010, 16'h0, 2, 16'h1234));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 2, 6'b000100, 16'h0, 3, 16'h1234));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 2, 6'b001000, 16'h0, 4, 16'h1234));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 2, 6'b010000, 16'h0, 5, 16'h1234));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 2, 6'b100000, BYP ? 16'h1234 : 16'h0, 6, 16'h1234));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 2, 6'b000000, 16'h1234, 0, 16'h0));
    // Back-to-back writes to r1: the younger one wins.
    vecs.push_back(alu(1, 1, 16'h0001, 6'b0, 1, 6'b000001, 16'h0, 1, 16'h0001));
    vecs.push_back(alu(1, 1, 16'h0002, 6'b0, 1, 6'b000011, 16'h0, 1, 16'h0002));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 1, 6'b000110, 16'h0, 3, 16'h0001));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 1, 6'b001100, 16'h0, 4, 16'h0001));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 1, 6'b011000, 16'h0, 5, 16'h0001));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 1, 6'b110000, BYP ? 16'h0001 : 16'h0, 6, 16'h0001));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 1, 6'b100000, BYP ? 16'h0002 : 16'h0001, 6, 16'h0002));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 1, 6'b000000, 16'h0002, 0, 16'h0));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 2, 6'b000000, 16'h1234, 0, 16'h0));
    // Flush of stages 1 and 2 together with an issue; older entries survive.
    vecs.push_back(alu(1, 3, 16'h00AA, 6'b0, 3, 6'b000001, 16'h0, 1, 16'h00AA));
    vecs.push_back(alu(1, 4, 16'h00BB, 6'b0, 3, 6'b000011, 16'h0, 1, 16'h00BB));
    vecs.push_back(alu(1, 5, 16'h00CC, 6'b0, 3, 6'b000111, 16'h0, 3, 16'h00AA));
    vecs.push_back(alu(1, 6, 16'h00DD, 6'b000011, 3, 6'b001100, 16'h0, 4, 16'h00AA));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 3, 6'b011000, 16'h0, 5, 16'h00AA));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 3, 6'b110000, BYP ? 16'h00AA : 16'h0, 6, 16'h00AA));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 3, 6'b100000, 16'h00AA, 6, 16'h00BB));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 4, 6'b000000, 16'h00BB, 0, 16'h0));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 5, 6'b000000, 16'h0, 0, 16'h0));
    vecs.push_back(alu(0, 0, 16'h0, 6'b0, 6, 6'b000000, 16'h0, 0, 16'h0));

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Reset clears the register file.
    doReset();
    bus.rd_num_in = 3'd2;
    #1;
    checkOutput("rst2.rd", 32'(bus.rd_data_out), 32'h0);

    // Stall for 3 cycles with a retiring entry at stage 6 and an issue presented.
    drive(1'b1, 3'd7, 1'b1, 1'b0, 16'h7777, 1'b0, 16'h0, 1'b0, 6'b0);
    tick();
    bubble();
    for (int i = 0; i < 5; i++) tick();
    checkOutput("stall.pre", 32'(bus.write_m_out), 32'b100000);
    bus.rd_num_in = 3'd7;
    drive(1'b1, 3'd1, 1'b1, 1'b0, 16'h9999, 1'b0, 16'h0, 1'b1, 6'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall%0d.write", i), 32'(bus.write_m_out), 32'b100000);
      checkOutput($sformatf("stall%0d.data6", i), 32'(stage_data(6)), 32'h7777);
      checkOutput($sformatf("stall%0d.rd", i), 32'(bus.rd_data_out), 32'h0);
    end
    bubble();
    tick();
    checkOutput("unstall.write", 32'(bus.write_m_out), 32'h0);
    checkOutput("unstall.rd", 32'(bus.rd_data_out), 32'h7777);

    // Load waits at stage 3, freezes the pipe, then is filled and moves on.
    doReset();
    drive(1'b1, 3'd5, 1'b1, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 6'b0);
    tick();
    checkOutput("ld1.pend", 32'(bus.pending_m_out), 32'b000001);
    checkOutput("ld1.busy", 32'(bus.busy_out), 32'h0);
    bubble();
    tick();
    tick();
    checkOutput("ld3.pend", 32'(bus.pending_m_out), 32'b000100);
    checkOutput("ld3.busy", 32'(bus.busy_out), 32'h1);
    drive(1'b1, 3'd6, 1'b1, 1'b0, 16'h1111, 1'b0, 16'h0, 1'b0, 6'b0);
    tick();
    checkOutput("ldfrz.write", 32'(bus.write_m_out), 32'b000100);
    checkOutput("ldfrz.busy", 32'(bus.busy_out), 32'h1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 6'b0);
    #1;
    checkOutput("ldmem.busy", 32'(bus.busy_out), 32'h0);
    tick();
    checkOutput("ldfill.pend", 32'(bus.pending_m_out), 32'h0);
    checkOutput("ldfill.write", 32'(bus.write_m_out), 32'b001000);
    checkOutput("ldfill.data4", 32'(stage_data(4)), 32'hBEEF);
    bubble();
    tick();
    tick();
    bus.rd_num_in = 3'd5;
    tick();
    checkOutput("ldret.rd", 32'(bus.rd_data_out), 32'hBEEF);

    // Fill while stalled: entry stays at stage 3 with pending cleared.
    doReset();
    drive(1'b1, 3'd4, 1'b1, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 6'b0);
    tick();
    bubble();
    tick();
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hCAFE, 1'b1, 6'b0);
    tick();
    checkOutput("sfill.pend", 32'(bus.pending_m_out), 32'h0);
    checkOutput("sfill.write", 32'(bus.write_m_out), 32'b000100);
    checkOutput("sfill.data3", 32'(stage_data(3)), 32'hCAFE);
    checkOutput("sfill.busy", 32'(bus.busy_out), 32'h0);
    bubble();
    tick();
    checkOutput("sfill2.data4", 32'(stage_data(4)), 32'hCAFE);
    checkOutput("sfill2.write", 32'(bus.write_m_out), 32'b001000);

    // Flushing a held pending load releases the hold.
    doReset();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 6'b0);
    tick();
    bubble();
    tick();
    tick();
    checkOutput("fl.busy0", 32'(bus.busy_out), 32'h1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 6'b000100);
    tick();
    checkOutput("fl.pend", 32'(bus.pending_m_out), 32'h0);
    checkOutput("fl.busy", 32'(bus.busy_out), 32'h0);
    drive(1'b1, 3'd1, 1'b1, 1'b0, 16'h4242, 1'b0, 16'h0, 1'b0, 6'b0);
    tick();
    checkOutput("fl.resume", 32'(bus.write_m_out), 32'b000001);
    checkOutput("fl.data1", 32'(stage_data(1)), 32'h4242);

    // Async reset mid-cycle drops the retirement that was about to happen.
    doReset();
    drive(1'b1, 3'd6, 1'b1, 1'b0, 16'hABCD, 1'b0, 16'h0, 1'b0, 6'b0);
    tick();
    bubble();
    for (int i = 0; i < 5; i++) tick();
    checkOutput("ar.pre", 32'(bus.write_m_out), 32'b100000);
    bus.rd_num_in = 3'd6;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar.write", 32'(bus.write_m_out), 32'h0);
    checkOutput("ar.data6", 32'(stage_data(6)), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("ar.rd", 32'(bus.rd_data_out), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/writeback_pipe.md
# writeback_pipe

In-flight result pipeline and register-file writer, the producer side of the per-operand forwarding muxes. Each issued instruction's destination number, write flag and result travel through DEPTH age-ordered stages. The block publishes the per-stage num/data/write triples the forwarding muxes consume, and retires the oldest stage into an internal 8x16 register file. It also absorbs late load data and raises a hold request while a load result is outstanding.

## Interface
- DEPTH, 6, number of in-flight stages; stage k holds the instruction issued k advances ago (t=-k)
- DATA_W, 16, result width
- REG_W, 3, register number width (2**REG_W registers)
- LOAD_STAGE, 3, stage at which load data is accepted; 1 <= LOAD_STAGE < DEPTH

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active-high
- issue_valid_in  input  1  new instruction enters stage 1
- issue_num_in  input  REG_W  destination register
- issue_write_in  input  1  instruction writes a register
- issue_load_in  input  1  result arrives later via mem_*; issue_data_in ignored
- issue_data_in  input  DATA_W  ALU result
- mem_valid_in  input  1  load data valid this cycle
- mem_data_in  input  DATA_W  load data
- stall_in  input  1  external hold
- flush_mask_in  input  DEPTH  bit k-1 kills post-edge stage k
- num_m_out  output  DEPTH*REG_W  stage k at bits [k*REG_W-1 -: REG_W]
- data_m_out  output  DEPTH*DATA_W  same packing
- write_m_out  output  DEPTH  bit k-1 = stage k write flag
- pending_m_out  output  DEPTH  stage k data not yet valid
- busy_out  output  1  internal hold active
- rd_num_in  input  REG_W  register-file read address
- rd_data_out  output  DATA_W  combinational read data

## Operation
- Advance = !stall_in && !busy_out. On advance, stage k+1 <= stage k, and stage 1 <= issue entry. The issue entry is write = issue_valid_in && issue_write_in, pending = issue_valid_in && issue_load_in. If issue_valid_in=0, stage 1 becomes a bubble (write=0, pending=0).
- Without advance, all stages hold and issue_* is ignored. The issuer must re-present the instruction.
- busy_out = pending[LOAD_STAGE] && !mem_valid_in (combinational).
- Load fill: when mem_valid_in=1 and pending[LOAD_STAGE]=1, that entry's data <= mem_data_in and pending <= 0. The updated entry moves to LOAD_STAGE+1 if advancing, otherwise stays in place. mem_valid_in with no pending entry at LOAD_STAGE is ignored.
- Retirement: on advance, if stage DEPTH has write=1, regfile[num] <= data. Register 0 is not special.
- Flush: applied after the shift/hold, at the same edge. For each set bit k-1, stage k gets write=0 and pending=0. A flush can kill the entry that is being issued (bit 0). It can also kill a held pending load, which clears busy_out on the next cycle.
- Pending entries never pass LOAD_STAGE. An entry pending at stage below LOAD_STAGE keeps advancing normally.

## Timing
- Reset: all write, pending, num and data fields are 0. The register file is all 0. busy_out=0.
- Issued at edge N: visible as stage 1 after N. Without holds, retired to the register file at edge N+DEPTH.
- All per-stage outputs are direct register outputs, with no combinational path from inputs.
- Stall with mem_valid_in: the fill still occurs, and the entry holds with pending=0.
- Reset asserted mid-operation: state clears immediately and asynchronously. The retirement in flight is lost.

## Configuration
- WB_BYPASS_EN defined: if a retirement write to rd_num_in is occurring this cycle, rd_data_out returns the retiring data (write-through).
- WB_BYPASS_EN undefined: rd_data_out returns the stored register value, and the new value is visible the cycle after the write.

## Structure
- Shared package kaiser_pkg: DATA_W/REG_W constants, stage_t struct {num, data, write, pending}, and the default DEPTH value.
- Sub-module regfile_8x16: asynchronous read, synchronous write, async-reset to 0, with the WB_BYPASS_EN logic. The stage pipeline stays in writeback_pipe.

## Test plan
- Reset then issue num=2, data=0x1234, write=1 with no stalls: the entry appears in stage 1 through stage 6 on consecutive cycles, and rd_num_in=2 returns 0x1234 after the 6th edge (same cycle if WB_BYPASS_EN).
- Load issued to num=5 with mem_valid_in low: busy_out=1 once the load reaches stage 3 and the pipeline freezes. Then mem_valid_in=1, mem_data_in=0xBEEF: busy_out drops, and stage 4 holds 0xBEEF with pending=0 on the next cycle.
- stall_in=1 for 3 cycles with entries in flight: all outputs stay constant, there are no register-file writes, and the issued entry is dropped.
- flush_mask_in=6'b000011 together with an issue: the new stage 1 and the new stage 2 both show write=0, and older stages are unaffected.
- Flush of a pending load at stage 3 while busy: pending clears, busy_out=0 next cycle, and advance resumes.
- Two writes to num=1 (0x0001 then 0x0002) issued back-to-back: after retirement the register file holds 0x0002.
